// File: rtl/a_hist_buffer.sv
// Activation history buffer: keeps the last DEPTH captured activation vectors
// for back-prop, with a combinational read select into the history.
module a_hist_buffer #(
  parameter int          WIDTH         = 16,
  parameter int          CHANNELS      = 2,
  parameter int          DEPTH         = 4,
  parameter logic [3:0]  CAPTURE_PHASE = 4'd1,
  parameter int          SEL_W         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                step,
  input  logic [3:0]                controller,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] a_in,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [CHANNELS*WIDTH-1:0] a_out,
  output logic                      out_valid,
  output logic [SEL_W:0]            count,
  output logic                      full,
  output logic                      cap_ack
);

  localparam int AW = CHANNELS * WIDTH;
  localparam logic [SEL_W:0] DEPTH_C = (SEL_W + 1)'(DEPTH);

  logic [AW-1:0] entry_q [DEPTH];
  logic [AW-1:0] entry_d [DEPTH];
  logic [SEL_W:0] count_q, count_d;
  logic           cap_ack_q, cap_ack_d;
  logic           cap;

  assign cap = (step != 4'd0) && (controller == CAPTURE_PHASE) && !flush;

  // Flush wins over a simultaneous capture; the capture is simply dropped.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) entry_d[k] = entry_q[k];
    count_d   = count_q;
    cap_ack_d = 1'b0;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) entry_d[k] = '0;
      count_d = '0;
    end else if (cap) begin
      entry_d[0] = a_in;
      for (int k = 1; k < DEPTH; k++) entry_d[k] = entry_q[k-1];
      count_d   = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
      cap_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= '0;
      count_q   <= '0;
      cap_ack_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= entry_d[k];
      count_q   <= count_d;
      cap_ack_q <= cap_ack_d;
    end
  end

  // Selects outside the retained depth read as zero rather than aliasing.
  always_comb begin
    a_out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_sel == SEL_W'(k)) a_out = entry_q[k];
    end
  end

  assign out_valid = ({1'b0, rd_sel} < count_q);
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign cap_ack   = cap_ack_q;

endmodule

// File: tb/tb_a_hist_buffer.sv
// Bench for a_hist_buffer: directed scenarios plus random traffic, all checked
// against a queue-based history model on every falling edge.
module tb_a_hist_buffer;

  localparam int WIDTH = 16;
  localparam int CHANNELS = 2;
  localparam int DEPTH = 4;
  localparam int SEL_W = 2;
  localparam int AW = WIDTH * CHANNELS;

  logic          clk;
  logic          rst;
  logic [3:0]    step;
  logic [3:0]    controller;
  logic          flush;
  logic [AW-1:0] a_in;
  logic [SEL_W-1:0] rd_sel;
  logic [AW-1:0] a_out;
  logic          out_valid;
  logic [SEL_W:0] count;
  logic          full;
  logic          cap_ack;

  int n_checks = 0;
  int n_fail = 0;
  bit done = 0;

  a_hist_buffer #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH),
    .CAPTURE_PHASE(4'd1), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .controller(controller),
    .flush(flush), .a_in(a_in), .rd_sel(rd_sel), .a_out(a_out),
    .out_valid(out_valid), .count(count), .full(full), .cap_ack(cap_ack)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: newest capture at the front of the queue
  logic [AW-1:0] exp_q[$];
  bit            m_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ack = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_ack = 1'b0;
    end else if (step != 4'd0 && controller == 4'd1) begin
      exp_q.push_front(a_in);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (!done) begin
      int sel;
      logic [AW-1:0] e_out;
      sel = int'(rd_sel);
      e_out = (sel < exp_q.size()) ? exp_q[sel] : '0;
      check("sb_a_out", 64'(a_out), 64'(e_out));
      check("sb_out_valid", 64'(out_valid), 64'(sel < exp_q.size()));
      check("sb_count", 64'(count), 64'(exp_q.size()));
      check("sb_full", 64'(full), 64'(exp_q.size() == DEPTH));
      check("sb_cap_ack", 64'(cap_ack), 64'(m_ack));
    end
  end

  // driver: apply inputs, then return 1 time unit after the capturing edge
  task automatic drive(input logic [3:0] s, input logic [3:0] c, input logic f,
                       input logic [AW-1:0] a);
    step = s;
    controller = c;
    flush = f;
    a_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [SEL_W-1:0] sel, input logic [AW-1:0] exp_data,
                      input logic exp_valid, input string name);
    rd_sel = sel;
    #1;
    check({name, "_data"}, 64'(a_out), 64'(exp_data));
    check({name, "_valid"}, 64'(out_valid), 64'(exp_valid));
  endtask

  initial begin
    rst = 1'b1;
    step = 4'd0;
    controller = 4'd1;
    flush = 1'b0;
    a_in = 32'h0800_0200;
    rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset then idle
    check("rst_count", 64'(count), 64'd0);
    check("rst_a_out", 64'(a_out), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 4'd1, 1'b0, 32'h0800_0200);
      check("idle_cap_ack", 64'(cap_ack), 64'd0);
      check("idle_count", 64'(count), 64'd0);
    end

    // single capture then hold
    drive(4'd1, 4'd1, 1'b0, 32'h0800_0200);
    check("cap1_ack", 64'(cap_ack), 64'd1);
    check("cap1_count", 64'(count), 64'd1);
    peek(2'd0, 32'h0800_0200, 1'b1, "cap1_rd0");
    drive(4'd1, 4'd2, 1'b0, 32'h1111_1111);
    check("hold2_ack", 64'(cap_ack), 64'd0);
    peek(2'd0, 32'h0800_0200, 1'b1, "hold2_rd0");
    drive(4'd1, 4'd3, 1'b0, 32'h1111_1111);
    check("hold3_ack", 64'(cap_ack), 64'd0);
    check("hold3_count", 64'(count), 64'd1);

    // history depth A..E
    drive(4'd1, 4'd2, 1'b1, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      drive(4'(i), 4'd1, 1'b0, {16'(i), 16'(i)});
      if (i == 4) begin
        check("depth_full_d", 64'(full), 64'd1);
        check("depth_count_d", 64'(count), 64'd4);
      end
    end
    check("depth_full_e", 64'(full), 64'd1);
    check("depth_count_e", 64'(count), 64'd4);
    drive(4'd5, 4'd2, 1'b0, 32'hdead_beef);
    peek(2'd0, 32'h0005_0005, 1'b1, "depth_e");
    peek(2'd1, 32'h0004_0004, 1'b1, "depth_d");
    peek(2'd2, 32'h0003_0003, 1'b1, "depth_c");
    peek(2'd3, 32'h0002_0002, 1'b1, "depth_b");

    // validity boundary with negative values
    drive(4'd1, 4'd2, 1'b1, 32'h0);
    drive(4'd1, 4'd1, 1'b0, 32'h0A00_0A00);
    drive(4'd2, 4'd1, 1'b0, 32'hF600_F600);
    drive(4'd2, 4'd0, 1'b0, 32'h0);
    peek(2'd1, 32'h0A00_0A00, 1'b1, "bnd_x");
    peek(2'd2, 32'h0, 1'b0, "bnd_empty");
    peek(2'd0, 32'hF600_F600, 1'b1, "bnd_y_sign");

    // flush priority over capture
    drive(4'd1, 4'd2, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) drive(4'd3, 4'd1, 1'b0, 32'h1234_0000 + 32'(i));
    check("fl_pre_count", 64'(count), 64'd3);
    drive(4'd3, 4'd1, 1'b1, 32'h5555_5555);
    check("fl_count", 64'(count), 64'd0);
    check("fl_ack", 64'(cap_ack), 64'd0);
    for (int k = 0; k < DEPTH; k++) peek(SEL_W'(k), 32'h0, 1'b0, "fl_zero");
    rd_sel = '0;
    drive(4'd4, 4'd1, 1'b0, 32'h7777_8888);
    check("fl_post_count", 64'(count), 64'd1);

    // async reset between edges while full
    for (int i = 0; i < 4; i++) drive(4'd5, 4'd1, 1'b0, 32'hABCD_0000 + 32'(i));
    drive(4'd5, 4'd2, 1'b0, 32'h0);
    check("ar_pre_full", 64'(full), 64'd1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_a_out", 64'(a_out), 64'd0);
    check("ar_full", 64'(full), 64'd0);
    @(posedge clk);
    #1;
    drive(4'd5, 4'd2, 1'b0, 32'h0);
    check("ar_hold_a_out", 64'(a_out), 64'd0);
    drive(4'd6, 4'd1, 1'b0, 32'h0102_0304);
    check("ar_recap_count", 64'(count), 64'd1);

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      rd_sel = SEL_W'($urandom_range(0, DEPTH - 1));
      drive(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            4'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0),
            $urandom());
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a_hist_buffer.md
Name: a_hist_buffer

Overview:
- Parametrised successor to the single-value activation hold register.
- Captures CHANNELS forward-prop activations (a2, a3, …) per step into a DEPTH-deep history shift buffer.
- Back-prop reads the activation from 1..DEPTH steps ago through a runtime read select.
- Sits between the forward-prop datapath and the back-prop/gradient units, gated by the step counter and controller phase.

Parameters:
- WIDTH, 16, bits per activation (signed, Q6.10 in current datapath)
- CHANNELS, 2, number of activations held per step
- DEPTH, 4, number of past steps retained (>=1)
- CAPTURE_PHASE, 4'd1, controller value on which capture occurs
- SEL_W, 2, width of rd_sel (>= clog2(DEPTH), >=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- step  in  4  current training step; 0 = idle/no capture
- controller  in  4  phase within step
- flush  in  1  synchronous clear of history (episode boundary)
- a_in  in  CHANNELS*WIDTH  packed activations; channel c at bits [c*WIDTH +: WIDTH]
- rd_sel  in  SEL_W  0 = most recent capture, k = k captures earlier
- a_out  out  CHANNELS*WIDTH  selected history entry, same packing
- out_valid  out  1  selected entry holds real data
- count  out  SEL_W+1  number of valid entries, saturates at DEPTH
- full  out  1  count == DEPTH
- cap_ack  out  1  one-cycle pulse, registered, high the cycle after a capture

Behaviour:
- Reset (async, rst=1): all entries = 0, count = 0, cap_ack = 0. Outputs are combinational from state: a_out = 0, out_valid = 0, full = 0.
- Capture condition, sampled at posedge clk: cap = (step != 0) && (controller == CAPTURE_PHASE) && !flush.
- On cap:
  - entry[0] <= a_in; entry[k] <= entry[k-1] for k = 1..DEPTH-1; entry[DEPTH-1] is discarded.
  - count <= min(count+1, DEPTH).
  - cap_ack <= 1.
- No cap: entries and count hold; cap_ack <= 0.
- Holding for several cycles (controller 2, 3, …, or step = 0) never alters contents.
- flush=1: entries <= 0, count <= 0, cap_ack <= 0. Flush has priority over a simultaneous capture; that capture is dropped.
- Read is combinational, zero latency after the register update: a_out = entry[rd_sel] when rd_sel < DEPTH, else 0.
- out_valid = (rd_sel < count). Entries beyond count read as 0 because of the reset/flush clear.
- Timing: a value captured at edge N is visible at rd_sel=0 from just after edge N, and at rd_sel=k after k further captures.
- No arithmetic is performed; all channels are bit-exact copies, with no sign extension or saturation.
- Back-to-back captures on consecutive cycles are legal and shift every cycle.
- rst asserted mid-operation clears immediately, independent of clk. Deassertion is synchronised externally; the first edge after deassertion may capture.
- All sequential state uses non-blocking assignments in a single always block sensitive to posedge clk or posedge rst.

Test Plan:
1. Reset then idle: rst high 2 cycles, step=0, controller=1, a_in={16'h0800,16'h0200} for 3 cycles -> count=0, a_out=0, out_valid=0, cap_ack never high.
2. Single capture/hold: step=1; controller=1 for one cycle with a_in={16'h0800,16'h0200}, then controller=2,3 with a_in changed to 16'h1111 pairs -> rd_sel=0 gives {0800,0200}; out_valid=1; count=1; cap_ack high exactly one cycle.
3. History depth: captures of A=0x0001, B=0x0002, C=0x0003, D=0x0004, E=0x0005 (both channels) on steps 1..5 -> after E, rd_sel=0..3 read E,D,C,B; A is discarded; count=4 and full=1 after D and stay there.
4. Validity boundary: after 2 captures (X=0x0A00, Y=0xF600 negative) -> rd_sel=1 returns X with out_valid=1; rd_sel=2 returns 0 with out_valid=0; a_out sign bits are preserved exactly.
5. Flush priority: flush=1 in the same cycle as a capture with count=3 -> next cycle count=0, all entries 0, cap_ack=0; a following capture gives count=1.
6. Async reset mid-step: rst pulsed between clock edges while full -> a_out=0 and count=0 before the next posedge; contents remain 0 until the next valid capture.
